cmp_1bit: RTL and testbench
===========================

# cmp_1bit

Registered magnitude comparator. Compares two unsigned operands A and B, and reports the result as three mutually exclusive flags: more, less and equal. The flags are updated on every rising clock edge. Default build is a single-bit comparator, used as the leaf compare cell in datapath and control logic. A WIDTH parameter lets the same block serve as a wider comparator.

## Interface
- WIDTH, default 1: operand width in bits; legal range is 1 to 64.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous reset, active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- more  output  1  registered flag, A > B.
- less  output  1  registered flag, A < B.
- equal  output  1  registered flag, A == B.

## Operation
- Combinational compare of A and B, treating both as unsigned.
- For WIDTH=1 the next-state values are:
  - more = A & ~B
  - less = ~A & B
  - equal = ~(A ^ B)
- For WIDTH>1 the result is decided by the most significant bit where A and B differ.
  - If that bit has A=1, more is set; if it has B=1, less is set.
  - If no bit differs, equal is set.
- The three next-state values are captured into three flops on every rising edge of clock. There is no enable and no hold.
- Invariant: outside reset, exactly one of more, less, equal is 1 (one-hot).
- During reset all three flags are 0. The all-zero pattern is reserved to mean "no valid result".
- Inputs that are X/Z produce undefined flags. No X-masking logic is required.

## Timing
- Latency is 1 cycle. Inputs present at rising edge N appear on the outputs immediately after edge N.
- Input changes between edges have no effect until the next edge. The outputs are glitch-free because they come straight from flops.
- Reset assertion clears all outputs immediately and asynchronously, independent of clock.
- While reset is held, outputs stay at 0 across clock edges.
- Reset release takes effect at the first rising edge after deassertion. That edge captures the current A and B, and the outputs become one-hot.
- Reset mid-stream: a result captured before reset is discarded. No stale value reappears after release.
- No handshake, backpressure or state machine. The only state is the three result flops.

## Structure
- Shared package cmp_pkg:
  - localparam bit positions CMP_MORE=2, CMP_LESS=1, CMP_EQ=0, for any consumer that packs the flags into a 3-bit vector.
  - Function cmp_onehot_ok(vec), which returns 1 when vec is one-hot. Used by assertions.
- Sub-module cmp_1bit_slice, purely combinational: inputs a, b, gt_in, lt_in; outputs gt_out, lt_out.
  - WIDTH slices form a chain from the MSB downward.
  - The first decided slice wins; lower slices pass the decision through.
  - equal is derived as ~gt & ~lt at the chain end.
- Top level holds the generate loop over the slices, the three output flops with async reset, and a simulation-only assertion: cmp_onehot_ok holds whenever reset is low, checked at each edge after the first edge following reset release.

## Test plan
- Reset check, WIDTH=1: assert reset with clock idle → more=less=equal=0 immediately. Toggle clock 2 cycles with reset held → outputs still 0.
- Exhaustive truth table, WIDTH=1. Apply each pair, one pair per cycle; each result appears one edge after it is applied:
  - A=0, B=0 → equal=1
  - A=0, B=1 → less=1
  - A=1, B=0 → more=1
  - A=1, B=1 → equal=1
  - The other two flags are 0 in every case.
- Latency and mid-cycle change: set A=1, B=0, then change to A=0, B=1 between edges → outputs still show the previous result until the next edge, then less=1.
- Reset mid-operation: with more=1 showing, pulse reset asynchronously → all flags drop to 0 at once. Release with A=1, B=1 → equal=1 at the next edge.
- Wider build, WIDTH=4:
  - A=4'b1000, B=4'b0111 → more=1
  - A=4'b0101, B=4'b0110 → less=1
  - A=B=4'b1111 → equal=1
  - A=4'b0000, B=4'b0001 → less=1
- One-hot assertion: random A and B for 1000 cycles, WIDTH=1 and WIDTH=8 → exactly one flag set every cycle after reset release, and each matches a reference compare of the operands sampled one edge earlier.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the cmp_1bit comparator family.
//   CMP_MORE / CMP_LESS / CMP_EQ : bit positions used when the three result
//                                  flags are packed into a 3-bit vector.
//   cmp_onehot_ok(vec)           : returns 1 when vec has exactly one bit set.
package cmp_pkg;

    localparam int CMP_MORE = 2;
    localparam int CMP_LESS = 1;
    localparam int CMP_EQ   = 0;

    // True when the packed {more, less, equal} vector is one-hot.
    function automatic logic cmp_onehot_ok(input logic [2:0] vec);
        logic ok_s;
        case (vec)
            3'b001:  ok_s = 1'b1;
            3'b010:  ok_s = 1'b1;
            3'b100:  ok_s = 1'b1;
            default: ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/cmp_1bit_slice.sv
// One bit of the magnitude-compare chain. Purely combinational.
//   a, b          : operand bits at this position
//   gt_in, lt_in  : decision coming from the more significant neighbour
//   gt_out, lt_out: decision handed to the less significant neighbour
// Once a more significant slice has decided (gt_in or lt_in set), the
// decision is passed through unchanged; otherwise this bit decides if a != b.
module cmp_1bit_slice
    import cmp_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    logic undecided_s;

    // Chain step: keep an upstream decision, otherwise decide on this bit.
    always_comb begin
        undecided_s = ~gt_in & ~lt_in;
        gt_out      = gt_in | (undecided_s & a & ~b);
        lt_out      = lt_in | (undecided_s & ~a & b);
    end

endmodule

// File: rtl/cmp_1bit.sv
// Registered unsigned magnitude comparator.
//   WIDTH  : operand width, 1..64 (default 1, the leaf compare cell)
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high; forces all flags to 0
//   A, B   : unsigned operands
//   more   : registered A > B
//   less   : registered A < B
//   equal  : registered A == B
// Outside reset exactly one flag is set; all-zero means "no valid result".
module cmp_1bit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             more,
    output logic             less,
    output logic             equal
);

    // gt_chain[WIDTH]/lt_chain[WIDTH] seed the MSB slice as "undecided";
    // index 0 carries the final decision out of the LSB slice.
    logic [WIDTH:0] gt_chain_s;
    logic [WIDTH:0] lt_chain_s;

    assign gt_chain_s[WIDTH] = 1'b0;
    assign lt_chain_s[WIDTH] = 1'b0;

    genvar gi;
    generate
        for (gi = WIDTH - 1; gi >= 0; gi--) begin : g_slice
            cmp_1bit_slice u_slice (
                .a      (A[gi]),
                .b      (B[gi]),
                .gt_in  (gt_chain_s[gi+1]),
                .lt_in  (lt_chain_s[gi+1]),
                .gt_out (gt_chain_s[gi]),
                .lt_out (lt_chain_s[gi])
            );
        end
    endgenerate

    logic [2:0] flags_d;
    logic       more_q;
    logic       less_q;
    logic       equal_q;

    // Pack the chain result; equal is simply "neither greater nor less".
    always_comb begin
        flags_d           = 3'b000;
        flags_d[CMP_MORE] = gt_chain_s[0];
        flags_d[CMP_LESS] = lt_chain_s[0];
        flags_d[CMP_EQ]   = ~gt_chain_s[0] & ~lt_chain_s[0];
    end

    // Result flops: capture every edge, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            more_q  <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            more_q  <= flags_d[CMP_MORE];
            less_q  <= flags_d[CMP_LESS];
            equal_q <= flags_d[CMP_EQ];
        end
    end

    assign more  = more_q;
    assign less  = less_q;
    assign equal = equal_q;

    // Flags sampled at an edge reflect the previous edge's capture, so the
    // check is only meaningful when reset was also low at that previous edge.
    a_onehot : assert property (
        @(posedge clock) disable iff (reset)
        !$past(reset) |-> cmp_onehot_ok({more_q, less_q, equal_q})
    );

endmodule

// File: tb/tb_cmp_1bit.sv
// Directed and random self-checking bench for cmp_1bit at WIDTH 1, 4 and 8.
module tb_cmp_1bit;

    logic       clock;
    logic       reset;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       more1, less1, equal1;
    logic       more4, less4, equal4;
    logic       more8, less8, equal8;

    int n_checks;
    int n_fail;

    cmp_1bit #(.WIDTH(1)) u_w1 (
        .clock(clock), .reset(reset), .A(a1), .B(b1),
        .more(more1), .less(less1), .equal(equal1)
    );

    cmp_1bit #(.WIDTH(4)) u_w4 (
        .clock(clock), .reset(reset), .A(a4), .B(b4),
        .more(more4), .less(less4), .equal(equal4)
    );

    cmp_1bit #(.WIDTH(8)) u_w8 (
        .clock(clock), .reset(reset), .A(a8), .B(b8),
        .more(more8), .less(less8), .equal(equal8)
    );

    // Free-running clock, period 10, first rising edge at t=5.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference: plain unsigned relational operators.
    function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed {more,less,equal}=%b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        a8 = 8'h00; b8 = 8'h00;

        // Reset with clock idle: flags clear immediately.
        #1 reset = 1'b1;
        #1;
        check("rst_idle_w1", {more1, less1, equal1}, 3'b000);
        check("rst_idle_w4", {more4, less4, equal4}, 3'b000);
        check("rst_idle_w8", {more8, less8, equal8}, 3'b000);

        // Reset held across two edges: flags stay 0.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        tick();
        check("rst_held_w1", {more1, less1, equal1}, 3'b000);
        check("rst_held_w8", {more8, less8, equal8}, 3'b000);

        // Release; first edge captures A=0,B=0, then the rest of the table.
        reset = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        tick();
        check("tt_00", {more1, less1, equal1}, 3'b001);
        a1 = 1'b0; b1 = 1'b1;
        tick();
        check("tt_01", {more1, less1, equal1}, 3'b010);
        a1 = 1'b1; b1 = 1'b0;
        tick();
        check("tt_10", {more1, less1, equal1}, 3'b100);
        a1 = 1'b1; b1 = 1'b1;
        tick();
        check("tt_11", {more1, less1, equal1}, 3'b001);

        // Mid-cycle input change has no effect until the next edge.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        check("mid_before", {more1, less1, equal1}, 3'b100);
        #2 a1 = 1'b0; b1 = 1'b1;
        #2;
        check("mid_hold", {more1, less1, equal1}, 3'b100);
        tick();
        check("mid_after", {more1, less1, equal1}, 3'b010);

        // Reset mid-stream: async clear, no stale value after release.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        check("rst_mid_pre", {more1, less1, equal1}, 3'b100);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_async", {more1, less1, equal1}, 3'b000);
        a1 = 1'b1; b1 = 1'b1;
        tick();
        check("rst_mid_held", {more1, less1, equal1}, 3'b000);
        reset = 1'b0;
        #1;
        check("rst_mid_release", {more1, less1, equal1}, 3'b000);
        tick();
        check("rst_mid_eq", {more1, less1, equal1}, 3'b001);

        // WIDTH=4 directed vectors.
        a4 = 4'b1000; b4 = 4'b0111;
        tick();
        check("w4_msb_more", {more4, less4, equal4}, 3'b100);
        a4 = 4'b0101; b4 = 4'b0110;
        tick();
        check("w4_less", {more4, less4, equal4}, 3'b010);
        a4 = 4'b1111; b4 = 4'b1111;
        tick();
        check("w4_eq_ones", {more4, less4, equal4}, 3'b001);
        a4 = 4'b0000; b4 = 4'b0001;
        tick();
        check("w4_lsb_less", {more4, less4, equal4}, 3'b010);
        a4 = 4'b1001; b4 = 4'b1000;
        tick();
        check("w4_lsb_more", {more4, less4, equal4}, 3'b100);
        a4 = 4'b0000; b4 = 4'b0000;
        tick();
        check("w4_eq_zero", {more4, less4, equal4}, 3'b001);

        // WIDTH=8 boundary vectors.
        a8 = 8'hFF; b8 = 8'h00;
        tick();
        check("w8_max_min", {more8, less8, equal8}, 3'b100);
        a8 = 8'h7F; b8 = 8'h80;
        tick();
        check("w8_msb_less", {more8, less8, equal8}, 3'b010);

        // Random operands, 1000 cycles, checked against values applied
        // before the edge that just passed.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] exp1;
            logic [2:0] exp8;
            a1 = 1'($urandom_range(1, 0));
            b1 = 1'($urandom_range(1, 0));
            a8 = 8'($urandom_range(255, 0));
            b8 = 8'($urandom_range(255, 0));
            if (i % 8 == 0) b8 = a8;
            exp1 = ref_cmp({63'd0, a1}, {63'd0, b1});
            exp8 = ref_cmp({56'd0, a8}, {56'd0, b8});
            tick();
            check("rand_w1", {more1, less1, equal1}, exp1);
            check("rand_w8", {more8, less8, equal8}, exp8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
